// File: rtl/wb_trace_buffer_pkg.sv
// Shared types for the write-back trace buffer.
// Optional timestamp storage is enabled by defining WB_TRACE_TIMESTAMP_EN.
package wb_trace_buffer_pkg;

    localparam int TRACE_DEPTH_DEFAULT = 16;
    localparam int NUM_WB_PORTS        = 4;
    localparam int TS_W                = 16;

    typedef struct packed {
        logic [4:0]      rd;
        logic [31:0]     data;
`ifdef WB_TRACE_TIMESTAMP_EN
        logic [TS_W-1:0] ts;
`endif
    } trace_entry_t;

    typedef enum logic [2:0] {
        SEL_DATA_LO = 3'b000,
        SEL_DATA_HI = 3'b001,
        SEL_RD      = 3'b010,
        SEL_STATUS  = 3'b011,
        SEL_TS      = 3'b100
    } trace_sel_e;

endpackage

// File: rtl/wb_trace_buffer_if.sv
// One write-back port as seen by the trace buffer.
// Handshake: a port carries a result in a cycle where valid is high; there is no backpressure.
interface wb_ifc;
    logic        valid;
    logic        uses_rd;
    logic [4:0]  rd;
    logic [31:0] data;

    modport master (output valid, uses_rd, rd, data);
    modport slave  (input  valid, uses_rd, rd, data);
endinterface

// File: rtl/wb_trace_buffer_compactor.sv
// Combinational packer: maps captured ports to consecutive FIFO slots, lowest port first,
// limited by the free space available at the start of the cycle.
module wb_compactor #(
    parameter int CW = 5
) (
    input  logic [3:0]      cap_i,
    input  logic [CW-1:0]   free_i,
    output logic [3:0][1:0] offset_o,
    output logic [3:0]      store_o,
    output logic [2:0]      push_cnt_o,
    output logic            drop_o
);

    always_comb begin
        int run;
        int cnt;
        run        = 0;
        cnt        = 0;
        offset_o   = '0;
        store_o    = '0;
        for (int k = 0; k < 4; k++) begin
            offset_o[k] = 2'(run);
            if (cap_i[k]) begin
                // Lower ports claim space first, so every earlier captured port was also stored.
                if (run < int'(free_i)) begin
                    store_o[k] = 1'b1;
                    cnt++;
                end
                run++;
            end
        end
        push_cnt_o = 3'(cnt);
        drop_o     = |(cap_i & ~store_o);
    end

endmodule

// File: rtl/wb_trace_buffer.sv
// Captures destination-register write-backs from four ports into a FIFO for board-level
// inspection; define WB_TRACE_TIMESTAMP_EN to tag each entry with a 16-bit cycle stamp.
module wb_trace_buffer
    import wb_trace_buffer_pkg::*;
#(
    parameter int TRACE_DEPTH = TRACE_DEPTH_DEFAULT
) (
    input  logic                         clk,
    input  logic                         reset,
    wb_ifc.slave                         i_wb [NUM_WB_PORTS],
    input  logic                         freeze,
    input  logic                         rd_next,
    input  logic [2:0]                   sel,
    output logic [15:0]                  o_disp,
    output logic [$clog2(TRACE_DEPTH):0] o_count,
    output logic                         o_overflow
);

    localparam int AW = $clog2(TRACE_DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             rd_next_q;
    trace_entry_t     mem_q [TRACE_DEPTH];

    logic [3:0]       cap;
    trace_entry_t     port_entry [NUM_WB_PORTS];
    logic [CW-1:0]    free_space;
    logic [3:0][1:0]  offset;
    logic [3:0]       store;
    logic [2:0]       push_cnt;
    logic             drop;
    logic             pop;
    trace_entry_t     head;

`ifdef WB_TRACE_TIMESTAMP_EN
    logic [TS_W-1:0]  ts_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) ts_q <= '0;
        else       ts_q <= ts_q + 1'b1;
    end
`endif

    for (genvar g = 0; g < NUM_WB_PORTS; g++) begin : g_port
        assign cap[g] = i_wb[g].valid && i_wb[g].uses_rd && !freeze;
`ifdef WB_TRACE_TIMESTAMP_EN
        assign port_entry[g] = '{rd: i_wb[g].rd, data: i_wb[g].data, ts: ts_q};
`else
        assign port_entry[g] = '{rd: i_wb[g].rd, data: i_wb[g].data};
`endif
    end

    // Space is judged before this cycle's pop, so a pop never makes room for same-cycle pushes.
    assign free_space = CW'(TRACE_DEPTH) - count_q;

    wb_compactor #(.CW(CW)) u_compactor (
        .cap_i      (cap),
        .free_i     (free_space),
        .offset_o   (offset),
        .store_o    (store),
        .push_cnt_o (push_cnt),
        .drop_o     (drop)
    );

    assign pop = rd_next && !rd_next_q && (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(push_cnt);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + CW'(push_cnt) - CW'(pop);
        ovf_d    = ovf_q | drop;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            rd_next_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            rd_next_q <= rd_next;
        end
    end

    // Storage is not reset; the pointers alone define which slots are live.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int k = 0; k < NUM_WB_PORTS; k++) begin
                if (store[k]) mem_q[wr_ptr_q + AW'(offset[k])] <= port_entry[k];
            end
        end
    end

    assign head = mem_q[rd_ptr_q];

    always_comb begin
        o_disp = '0;
        case (trace_sel_e'(sel))
            SEL_DATA_LO: if (count_q != '0) o_disp = head.data[15:0];
            SEL_DATA_HI: if (count_q != '0) o_disp = head.data[31:16];
            SEL_RD:      if (count_q != '0) o_disp = {11'b0, head.rd};
            SEL_STATUS:  o_disp = {ovf_q, 8'b0, 7'(count_q)};
`ifdef WB_TRACE_TIMESTAMP_EN
            SEL_TS:      if (count_q != '0) o_disp = head.ts;
`endif
            default:     o_disp = '0;
        endcase
    end

    assign o_count    = count_q;
    assign o_overflow = ovf_q;

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Self-checking bench for wb_trace_buffer: vector table, directed corner sequences and a
// queue-based reference FIFO compared after every clock.
module tb_wb_trace_buffer;

    localparam int DEPTH = 16;

    typedef struct {
        logic [3:0] valid;
        logic [3:0] uses;
        logic       frz;
        logic       rdn;
        int         exp_count;
        logic       exp_ovf;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    always #10 clk = ~clk;

    wb_ifc wb [4] ();

    logic [3:0]       tb_valid, tb_uses;
    logic [3:0][4:0]  tb_rd;
    logic [3:0][31:0] tb_data;
    logic             freeze, rd_next;
    logic [2:0]       sel;
    logic [15:0]      o_disp;
    logic [4:0]       o_count;
    logic             o_overflow;

    for (genvar g = 0; g < 4; g++) begin : g_drv
        assign wb[g].valid   = tb_valid[g];
        assign wb[g].uses_rd = tb_uses[g];
        assign wb[g].rd      = tb_rd[g];
        assign wb[g].data    = tb_data[g];
    end

    wb_trace_buffer #(.TRACE_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .i_wb       (wb),
        .freeze     (freeze),
        .rd_next    (rd_next),
        .sel        (sel),
        .o_disp     (o_disp),
        .o_count    (o_count),
        .o_overflow (o_overflow)
    );

    int          checks;
    int          errors;
    logic [52:0] exp_q [$];   // {ts, rd, data}
    logic        m_ovf;
    logic        m_rdq;
    logic [15:0] m_ts;
    vec_t        vecs [14];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [15:0] exp_disp(input int s);
        logic [15:0] r;
        logic [52:0] h;
        r = '0;
        if (s == 3) begin
            r = {m_ovf, 8'b0, 7'(exp_q.size())};
        end else if (exp_q.size() != 0) begin
            h = exp_q[0];
            case (s)
                0: r = h[15:0];
                1: r = h[31:16];
                2: r = {11'b0, h[36:32]};
`ifdef WB_TRACE_TIMESTAMP_EN
                4: r = h[52:37];
`endif
                default: r = '0;
            endcase
        end
        return r;
    endfunction

    task automatic check_all(input string name);
        check({name, " count"}, 32'(o_count), 32'(exp_q.size()));
        check({name, " ovf"}, 32'(o_overflow), 32'(m_ovf));
        for (int s = 0; s < 8; s++) begin
            sel = 3'(s);
            #1;
            check($sformatf("%s sel%0d", name, s), 32'(o_disp), 32'(exp_disp(s)));
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_ovf = 1'b0;
        m_rdq = 1'b0;
        m_ts  = '0;
    endtask

    task automatic idle();
        tb_valid = '0;
        tb_uses  = '0;
        freeze   = 1'b0;
    endtask

    // Advance the reference FIFO for the inputs currently driven, clock the DUT, then compare.
    task automatic step(input string name);
        int          free;
        logic        do_pop;
        logic [52:0] pend [$];
        free   = DEPTH - exp_q.size();
        do_pop = rd_next && !m_rdq && (exp_q.size() != 0);
        for (int k = 0; k < 4; k++) begin
            if (tb_valid[k] && tb_uses[k] && !freeze) begin
                if (free > 0) begin
                    pend.push_back({m_ts, tb_rd[k], tb_data[k]});
                    free--;
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
        if (do_pop) void'(exp_q.pop_front());
        foreach (pend[j]) exp_q.push_back(pend[j]);
        m_rdq = rd_next;
        m_ts  = m_ts + 16'd1;
        @(posedge clk);
        #1;
        check_all(name);
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        checks  = 0;
        errors  = 0;
        reset   = 1'b1;
        rd_next = 1'b0;
        sel     = '0;
        tb_rd   = '0;
        tb_data = '0;
        idle();
        model_reset();

        vecs[0]  = '{4'b0101, 4'b0101, 1'b0, 1'b0,  2, 1'b0};
        vecs[1]  = '{4'b0000, 4'b0000, 1'b0, 1'b0,  2, 1'b0};
        vecs[2]  = '{4'b0000, 4'b0000, 1'b0, 1'b1,  1, 1'b0};
        vecs[3]  = '{4'b1111, 4'b1000, 1'b0, 1'b0,  2, 1'b0};
        vecs[4]  = '{4'b1111, 4'b1111, 1'b1, 1'b0,  2, 1'b0};
        vecs[5]  = '{4'b1010, 4'b1111, 1'b0, 1'b1,  3, 1'b0};
        vecs[6]  = '{4'b0000, 4'b0000, 1'b0, 1'b1,  3, 1'b0};
        vecs[7]  = '{4'b0000, 4'b0000, 1'b0, 1'b0,  3, 1'b0};
        vecs[8]  = '{4'b0011, 4'b0011, 1'b0, 1'b1,  4, 1'b0};
        vecs[9]  = '{4'b1111, 4'b1111, 1'b0, 1'b0,  8, 1'b0};
        vecs[10] = '{4'b1111, 4'b1111, 1'b0, 1'b0, 12, 1'b0};
        vecs[11] = '{4'b0110, 4'b1111, 1'b0, 1'b0, 14, 1'b0};
        vecs[12] = '{4'b1111, 4'b1111, 1'b0, 1'b0, 16, 1'b1};
        vecs[13] = '{4'b1111, 4'b1111, 1'b0, 1'b1, 15, 1'b1};

        #5;
        check_all("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 14; i++) begin
            tb_valid = vecs[i].valid;
            tb_uses  = vecs[i].uses;
            freeze   = vecs[i].frz;
            rd_next  = vecs[i].rdn;
            for (int k = 0; k < 4; k++) begin
                tb_rd[k]   = 5'($urandom_range(0, 31));
                tb_data[k] = $urandom;
            end
            if (i == 0) begin
                tb_rd[0] = 5'd5; tb_data[0] = 32'h1111_2222;
                tb_rd[2] = 5'd7; tb_data[2] = 32'h3333_4444;
            end
            step($sformatf("vec%0d", i));
            check($sformatf("vec%0d tbl count", i), 32'(o_count), 32'(vecs[i].exp_count));
            check($sformatf("vec%0d tbl ovf", i), 32'(o_overflow), 32'(vecs[i].exp_ovf));
            if (i == 1) begin
                sel = 3'b000; #1; check("two ports data_lo", 32'(o_disp), 32'h2222);
                sel = 3'b010; #1; check("two ports rd", 32'(o_disp), 32'h0005);
            end
            if (i == 2) begin
                sel = 3'b010; #1; check("after pop rd", 32'(o_disp), 32'h0007);
            end
            if (i == 12) begin
                sel = 3'b011; #1; check("full status", 32'(o_disp), 32'h8010);
            end
        end
        idle();
        rd_next = 1'b0;
        step("settle");

        for (int n = 0; n < 40 && exp_q.size() != 0; n++) begin
            rd_next = 1'b1; step("drain hi");
            rd_next = 1'b0; step("drain lo");
        end
        check("drained count", 32'(o_count), 32'd0);
        rd_next = 1'b1;
        step("pop at empty");
        check("pop at empty count", 32'(o_count), 32'd0);
        check("pop at empty ovf", 32'(o_overflow), 32'd1);
        rd_next = 1'b0;
        step("pop at empty lo");

        tb_valid = 4'b0111;
        tb_uses  = 4'b0111;
        for (int k = 0; k < 4; k++) begin
            tb_rd[k]   = 5'(k + 9);
            tb_data[k] = $urandom;
        end
        step("held push");
        idle();
        rd_next = 1'b1;
        repeat (5) step("held high");
        rd_next = 1'b0;
        step("held release");
        check("held single pop", 32'(o_count), 32'd2);

        for (int i = 0; i < 60; i++) begin
            tb_valid = 4'($urandom_range(0, 15));
            tb_uses  = 4'(1 << $urandom_range(0, 3));
            freeze   = ($urandom_range(0, 7) == 0);
            rd_next  = (i % 2 == 1);
            for (int k = 0; k < 4; k++) begin
                tb_rd[k]   = 5'($urandom_range(0, 31));
                tb_data[k] = $urandom;
            end
            step("wrap");
        end
        idle();
        rd_next = 1'b0;
        step("wrap end");

        tb_valid = 4'hF;
        tb_uses  = 4'hF;
        reset    = 1'b1;
        #1;
        check("async reset count", 32'(o_count), 32'd0);
        check("async reset ovf", 32'(o_overflow), 32'd0);
        @(posedge clk);
        #1;
        check("reset hold count", 32'(o_count), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        idle();
        model_reset();
        step("post reset");

        for (int n = 0; n < 200 && m_ts != 16'd100; n++) step("ts idle");
        tb_valid   = 4'b0001;
        tb_uses    = 4'b0001;
        tb_rd[0]   = 5'd3;
        tb_data[0] = 32'hCAFE_F00D;
        step("ts capture");
        idle();
        sel = 3'b100;
        #1;
`ifdef WB_TRACE_TIMESTAMP_EN
        check("timestamp", 32'(o_disp), 32'h0064);
`else
        check("timestamp", 32'(o_disp), 32'h0000);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_trace_buffer.md
WB_TRACE_BUFFER -- requirements
Module: wb_trace_buffer

Interface
REQ-001 SHALL declare parameter TRACE_DEPTH, default 16, entry count of the trace FIFO (power of two, 4..64).
REQ-002 SHALL have port clk  input  1  sole clock, all state on posedge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port i_wb  wb_ifc[4] sink  4  write-back ports; fields used: valid, uses_rd, rd, data.
REQ-005 SHALL have port freeze  input  1  level; when high no new entries are captured.
REQ-006 SHALL have port rd_next  input  1  level from board button; each rising edge pops one entry.
REQ-007 SHALL have port sel  input  3  display selector.
REQ-008 SHALL have port o_disp  output  16  selected view of head entry or status.
REQ-009 SHALL have port o_count  output  $clog2(TRACE_DEPTH)+1  number of held entries.
REQ-010 SHALL have port o_overflow  output  1  sticky, some capture was dropped.

Function
REQ-011 SHALL treat port k as capturable when i_wb[k].valid && i_wb[k].uses_rd && !freeze.
REQ-012 SHALL write all capturable ports of one cycle into consecutive FIFO slots in ascending port order (compacted, no holes), at posedge.
REQ-013 SHALL compute free space from o_count at the start of the cycle; a pop in the same cycle does not create space for that cycle's pushes.
REQ-014 When capturable ports exceed free space, SHALL store the lowest-numbered ports that fit, drop the rest, and set o_overflow.
REQ-015 SHALL keep o_overflow set until reset.
REQ-016 SHALL register rd_next once and detect a rising edge as rd_next && !rd_next_q; a pop takes effect at the edge-detect posedge.
REQ-017 SHALL ignore a pop edge when o_count is 0; a pop SHALL NOT change o_overflow.
REQ-018 Simultaneous push and pop SHALL update o_count by pushes minus 1.
REQ-019 SHALL wrap write and read pointers modulo TRACE_DEPTH.
REQ-020 o_disp SHALL be combinational from head entry, o_count and sel:
- 000: data[15:0]
- 001: data[31:16]
- 010: {11'b0, rd}
- 011: {o_overflow, 8'b0, o_count zero-extended to 7 bits}
- 100: timestamp (see Configuration)
- others: 0
REQ-021 For sel 000/001/010/100 with o_count 0, o_disp SHALL be 0.
REQ-022 An entry captured at posedge N SHALL appear on o_disp after posedge N when the FIFO was empty.

Reset
REQ-023 Asserting reset SHALL immediately clear read/write pointers, o_count, o_overflow, rd_next_q and the timestamp counter; o_disp therefore reads 0 for all sel except 011 (also 0).
REQ-024 Reset mid-capture SHALL discard that cycle's pushes; stored data contents need no clearing.

Configuration
REQ-025 Macro WB_TRACE_TIMESTAMP_EN defined: SHALL keep a free-running 16-bit cycle counter (wraps 0xFFFF->0) and store its value with each entry; sel 100 shows it.
REQ-026 Macro undefined: SHALL omit counter and timestamp storage; sel 100 reads 0.

Structure
REQ-027 Shared package SHALL hold TRACE_DEPTH default, trace_entry_t (rd, data, optional timestamp) and trace_sel_e enum for sel codes.
REQ-028 Sub-module wb_compactor SHALL be combinational, producing per-port slot offsets and push count from the four capture flags and free space.

Verification
REQ-029 Reset, ports 0 and 2 valid (rd 5, data 0x11112222; rd 7, data 0x33334444) -> o_count 2; sel 000 = 0x2222, sel 010 = 0x0005; one rd_next edge -> sel 010 = 0x0007.
REQ-030 All 4 ports valid, uses_rd only on port 3 -> o_count rises by 1 only.
REQ-031 Fill to 14, then 4 valid ports -> ports 0,1 stored, o_count 16, o_overflow 1; sel 011 = 0x8010.
REQ-032 rd_next held high 5 cycles -> exactly one pop; pop edge at o_count 0 -> o_count stays 0.
REQ-033 Count 3, pop edge plus 2 pushes same cycle -> o_count 4; pointer wrap over 40 pushes/pops preserves order.
REQ-034 Macro defined, capture at cycle 100 after reset -> sel 100 = 0x0064; macro undefined -> 0x0000.
